// File: rtl/int_to_float.sv
// Multi-cycle int32 -> IEEE-754 single converter with strobe/ack stream handshake.
// Define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// GET_A     | input_a_ack high, waiting for an operand transfer
// CONVERT_0 | zero short-cut, otherwise take sign and magnitude
// NORMALISE | shift magnitude left one bit per cycle until bit 31 is set
// ROUND     | form 23-bit fraction, round (or truncate), fix exponent
// PACK      | assemble sign/exponent/fraction into output_z
// PUT_Z     | output_z_stb high, waiting for consumer ack

module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      state, state_n;
  logic [31:0] a, a_n;
  logic [31:0] value, value_n;
  logic [7:0]  exp, exp_n;
  logic [22:0] mant, mant_n;
  logic        sign, sign_n;
  logic        input_a_ack_n;
  logic [31:0] output_z_n;
  logic        output_z_stb_n;

  // Fraction excludes the hidden bit, so its carry-out is exactly the all-ones mantissa case.
  logic [23:0] frac_inc;
  assign frac_inc = {1'b0, value[30:8]} + 24'd1;

`ifdef INT_TO_FLOAT_ROUND_EN
  logic guard, rnd, sticky;
  assign guard  = value[7];
  assign rnd    = value[6];
  assign sticky = |value[5:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      a            <= 32'd0;
      value        <= 32'd0;
      exp          <= 8'd0;
      mant         <= 23'd0;
      sign         <= 1'b0;
      input_a_ack  <= 1'b0;
      output_z     <= 32'd0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_n;
      a            <= a_n;
      value        <= value_n;
      exp          <= exp_n;
      mant         <= mant_n;
      sign         <= sign_n;
      input_a_ack  <= input_a_ack_n;
      output_z     <= output_z_n;
      output_z_stb <= output_z_stb_n;
    end
  end

  always_comb begin
    state_n        = state;
    a_n            = a;
    value_n        = value;
    exp_n          = exp;
    mant_n         = mant;
    sign_n         = sign;
    input_a_ack_n  = input_a_ack;
    output_z_n     = output_z;
    output_z_stb_n = output_z_stb;

    case (state)
      GET_A: begin
        input_a_ack_n = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_n           = input_a;
          input_a_ack_n = 1'b0;
          state_n       = CONVERT_0;
        end
      end

      CONVERT_0: begin
        if (a == 32'd0) begin
          output_z_n     = 32'd0;
          output_z_stb_n = 1'b1;
          state_n        = PUT_Z;
        end else begin
          // 0x80000000 negates to itself and is then read as unsigned 2^31.
          sign_n  = a[31];
          value_n = a[31] ? (~a + 32'd1) : a;
          exp_n   = 8'd31;
          state_n = NORMALISE;
        end
      end

      NORMALISE: begin
        if (!value[31]) begin
          value_n = {value[30:0], 1'b0};
          exp_n   = exp - 8'd1;
        end else begin
          state_n = ROUND;
        end
      end

      ROUND: begin
        mant_n = value[30:8];
`ifdef INT_TO_FLOAT_ROUND_EN
        if (guard && (rnd || sticky || value[8])) begin
          mant_n = frac_inc[22:0];
          exp_n  = exp + {7'd0, frac_inc[23]};
        end
`endif
        state_n = PACK;
      end

      PACK: begin
        output_z_n     = {sign, exp + 8'd127, mant};
        output_z_stb_n = 1'b1;
        state_n        = PUT_Z;
      end

      PUT_Z: begin
        if (output_z_ack) begin
          output_z_stb_n = 1'b0;
          state_n        = GET_A;
        end
      end

      default: state_n = GET_A;
    endcase
  end

endmodule

// File: tb/tb_int_to_float.sv
// Directed vector bench for int_to_float: results, latency, handshake, backpressure, reset.
// Expected values follow INT_TO_FLOAT_ROUND_EN the same way the design does.

module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int tests = 0;
  int fails = 0;

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts a transfer; returns once the transfer edge has passed (time = edge0 + 1).
  task automatic send(input logic [31:0] a, input string name);
    int n;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check({name, " ack_wait"}, 32'(n < 10), 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = 32'hDEAD_BEEF;
    check({name, " ack_low"}, 32'(input_a_ack), 32'd0);
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (output_z_stb !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    lat = n;
  endtask

  task automatic consume(input string name);
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check({name, " stb_drop"}, 32'(output_z_stb), 32'd0);
    check({name, " ack_still_low"}, 32'(input_a_ack), 32'd0);
    @(posedge clk); #1;
    check({name, " ack_return"}, 32'(input_a_ack), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.a, v.name);
    wait_result(lat);
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " z"}, output_z, v.z);
    consume(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] held;

    vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 35, "one"};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 35, "minus_one"};
    vecs[2]  = '{32'h8000_0000, 32'hCF00_0000, 4,  "int_min"};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1,  "zero"};
    vecs[4]  = '{32'h0100_0001, 32'h4B80_0000, 11, "tie_even"};
    vecs[5]  = '{32'h0000_0064, 32'h42C8_0000, 29, "hundred"};
    vecs[6]  = '{32'h0000_0002, 32'h4000_0000, 34, "two"};
    vecs[7]  = '{32'hFFFF_FF9C, 32'hC2C8_0000, 29, "minus_hundred"};
    vecs[8]  = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 12, "exact_24bit"};
    vecs[9]  = '{32'h0100_0002, 32'h4B80_0001, 11, "exact_25bit"};
`ifdef INT_TO_FLOAT_ROUND_EN
    vecs[10] = '{32'h7FFF_FFFF, 32'h4F00_0000, 5,  "int_max"};
    vecs[11] = '{32'h0100_0003, 32'h4B80_0002, 11, "tie_odd"};
`else
    vecs[10] = '{32'h7FFF_FFFF, 32'h4EFF_FFFF, 5,  "int_max"};
    vecs[11] = '{32'h0100_0003, 32'h4B80_0001, 11, "tie_odd"};
`endif

    rst          = 1'b1;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset input_a_ack", 32'(input_a_ack), 32'd0);
    check("reset output_z_stb", 32'(output_z_stb), 32'd0);
    check("reset output_z", output_z, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result and strobe hold, producer strobe ignored.
    send(32'h0000_0064, "bp");
    wait_result(lat);
    check("bp latency", 32'(lat), 32'd29);
    held        = output_z;
    check("bp z", held, 32'h42C8_0000);
    input_a     = 32'h1234_5678;
    input_a_stb = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp hold z", output_z, 32'h42C8_0000);
      check("bp hold stb", 32'(output_z_stb), 32'd1);
      check("bp hold ack", 32'(input_a_ack), 32'd0);
    end
    input_a_stb = 1'b0;
    consume("bp");

    // Reset while normalising discards the operand and clears outputs.
    send(32'h0000_0001, "rst_mid");
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid pre stb", 32'(output_z_stb), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid input_a_ack", 32'(input_a_ack), 32'd0);
    check("rst_mid output_z_stb", 32'(output_z_stb), 32'd0);
    check("rst_mid output_z", output_z, 32'd0);
    @(posedge clk); #1;
    check("rst_mid ack_back", 32'(input_a_ack), 32'd1);
    check("rst_mid no_stale_stb", 32'(output_z_stb), 32'd0);
    run_vec('{32'h0000_0064, 32'h42C8_0000, 29, "after_rst"});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
